// File: rtl/id_ex_flow_reg_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : id_ex_flow_reg_pkg                                               |
// | Purpose : Shared width/state definitions for the ID->EX flow controller.   |
// |           Carries the rooth_defines set (`CPU_WIDTH, `REG_ADDR_WIDTH,       |
// |           `CSR_ADDR_WIDTH, `FLOW_RUN/`FLOW_BUBBLE/`FLOW_FLUSH) and a        |
// |           package view of them for typed use.                              |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef ROOTH_DEFINES_V
`define ROOTH_DEFINES_V
`define CPU_WIDTH       32
`define REG_ADDR_WIDTH  5
`define CSR_ADDR_WIDTH  12
`define FLOW_RUN        2'd0
`define FLOW_BUBBLE     2'd1
`define FLOW_FLUSH      2'd2
`endif

package id_ex_flow_reg_pkg;

  localparam int CPU_W  = `CPU_WIDTH;
  localparam int REG_AW = `REG_ADDR_WIDTH;
  localparam int CSR_AW = `CSR_ADDR_WIDTH;

  typedef enum logic [1:0] {
    FLOW_ST_RUN    = `FLOW_RUN,
    FLOW_ST_BUBBLE = `FLOW_BUBBLE,
    FLOW_ST_FLUSH  = `FLOW_FLUSH
  } flow_state_e;

  // Width of the flush down-counter: it only ever holds 0..n-1, but never
  // collapse to a zero-width vector when n is 1 or 2.
  function automatic int flush_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : id_ex_flow_reg_pkg

`default_nettype wire

// File: rtl/id_ex_flow_reg_sat_cnt.sv
// +----------------------------------------------------------------------------+
// | Module  : flow_sat_cnt                                                     |
// | Purpose : 32-bit saturating event counter with synchronous clear.          |
// |           Only built when ROOTH_FLOW_CNT_EN is defined, so the default     |
// |           build carries no orphan module.                                  |
// | Ports   : clk_i  in  1   clock                                              |
// |           clr_i  in  1   synchronous clear (dominates en_i)                 |
// |           en_i   in  1   count one event this cycle                         |
// |           cnt_o  out 32  current count, sticks at 32'hFFFF_FFFF             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef ROOTH_FLOW_CNT_EN
module flow_sat_cnt (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] count;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count <= 32'd0;
    end else if (en_i && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

  assign cnt_o = count;

endmodule : flow_sat_cnt
`endif

`default_nettype wire

// File: rtl/id_ex_flow_reg.sv
// +----------------------------------------------------------------------------+
// | Module  : id_ex_flow_reg                                                   |
// | Purpose : Decode->execute pipeline register and flow controller.           |
// |           Registers the decoded instruction into EX, inserts one bubble    |
// |           per load-use hazard (holding PC and IF/ID), and squashes the EX  |
// |           slot for FLUSH_CYCLES cycles after a taken jump.                 |
// | Config  : ROOTH_FLOW_CNT_EN - enables bubble/flush event counters;         |
// |           otherwise bubble_cnt_o/flush_cnt_o are constant zero.            |
// | Ports   : clk_i, rst_i (sync, active-high)                                 |
// |           id_*_i          decoded instruction + forwarded operands         |
// |           flow_wait_fc_i  load-use hazard request                          |
// |           jump_flush_i    taken jump/branch resolved in EX                 |
// |           ex_*_o          registered copies of id_*_i (zero on bubble)     |
// |           hold_pc_o       freeze PC (combinational)                        |
// |           hold_id_o       freeze IF/ID register (combinational)            |
// |           bubble_cnt_o    load-use bubbles inserted                        |
// |           flush_cnt_o     jumps that caused a flush                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module id_ex_flow_reg
  import id_ex_flow_reg_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [`CPU_WIDTH-1:0]      id_inst_addr_i,
  input  logic [`CPU_WIDTH-1:0]      id_reg1_data_i,
  input  logic [`CPU_WIDTH-1:0]      id_reg2_data_i,
  input  logic [`CPU_WIDTH-1:0]      id_csr_data_i,
  input  logic [`CPU_WIDTH-1:0]      id_imm_i,
  input  logic [ALU_OP_WIDTH-1:0]    id_alu_op_i,
  input  logic                       id_reg_wr_en_i,
  input  logic [`REG_ADDR_WIDTH-1:0] id_reg_wr_adder_i,
  input  logic                       id_csr_wr_en_i,
  input  logic [`CSR_ADDR_WIDTH-1:0] id_csr_wr_adder_i,
  input  logic                       flow_wait_fc_i,
  input  logic                       jump_flush_i,
  output logic                       ex_valid_o,
  output logic [`CPU_WIDTH-1:0]      ex_inst_addr_o,
  output logic [`CPU_WIDTH-1:0]      ex_reg1_data_o,
  output logic [`CPU_WIDTH-1:0]      ex_reg2_data_o,
  output logic [`CPU_WIDTH-1:0]      ex_csr_data_o,
  output logic [`CPU_WIDTH-1:0]      ex_imm_o,
  output logic [ALU_OP_WIDTH-1:0]    ex_alu_op_o,
  output logic                       ex_reg_wr_en_o,
  output logic [`REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_o,
  output logic                       ex_csr_wr_en_o,
  output logic [`CSR_ADDR_WIDTH-1:0] ex_csr_wr_adder_o,
  output logic                       hold_pc_o,
  output logic                       hold_id_o,
  output logic [31:0]                bubble_cnt_o,
  output logic [31:0]                flush_cnt_o
);

  localparam int                 CNT_W  = flush_cnt_width(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0]   RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  // FLUSH_CYCLES==1 means the jump cycle alone is the whole squash.
  localparam flow_state_e        JUMP_NEXT = (RELOAD != '0) ? FLOW_ST_FLUSH : FLOW_ST_RUN;

  flow_state_e      state;
  flow_state_e      next_state;
  logic [CNT_W-1:0] flush_left;
  logic [CNT_W-1:0] next_flush_left;

  logic             hazard_stall;
  logic             capture;

  // ---------------------------------------------------------------------------
  // State register (FSM + flush down-counter)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= FLOW_ST_RUN;
      flush_left <= '0;
    end else begin
      state      <= next_state;
      flush_left <= next_flush_left;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A jump wins over everything in every state; the hazard
  // is only honoured in RUN, so a BUBBLE never chains into a second bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state      = state;
    next_flush_left = flush_left;
    if (jump_flush_i) begin
      next_state      = JUMP_NEXT;
      next_flush_left = RELOAD;
    end else begin
      case (state)
        FLOW_ST_RUN: begin
          next_state = flow_wait_fc_i ? FLOW_ST_BUBBLE : FLOW_ST_RUN;
        end
        FLOW_ST_BUBBLE: begin
          next_state = FLOW_ST_RUN;
        end
        FLOW_ST_FLUSH: begin
          // Leave on the cycle the counter would reach zero; a stray zero
          // count also falls back to RUN rather than wrapping.
          if (flush_left <= CNT_W'(1)) begin
            next_flush_left = '0;
            next_state      = FLOW_ST_RUN;
          end else begin
            next_flush_left = flush_left - CNT_W'(1);
          end
        end
        default: begin
          next_state      = FLOW_ST_RUN;
          next_flush_left = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: stall request and the capture/bubble decision for EX.
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard_stall = (state == FLOW_ST_RUN) && flow_wait_fc_i && !jump_flush_i;
    capture      = (state != FLOW_ST_FLUSH) && !jump_flush_i && !hazard_stall;
  end

  assign hold_pc_o = hazard_stall;
  assign hold_id_o = hazard_stall;

  // ---------------------------------------------------------------------------
  // EX payload register. A bubble clears every field, not just the enables,
  // so EX never sees stale operands on a squashed slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || !capture) begin
      ex_valid_o        <= 1'b0;
      ex_inst_addr_o    <= '0;
      ex_reg1_data_o    <= '0;
      ex_reg2_data_o    <= '0;
      ex_csr_data_o     <= '0;
      ex_imm_o          <= '0;
      ex_alu_op_o       <= '0;
      ex_reg_wr_en_o    <= 1'b0;
      ex_reg_wr_adder_o <= '0;
      ex_csr_wr_en_o    <= 1'b0;
      ex_csr_wr_adder_o <= '0;
    end else begin
      ex_valid_o        <= id_valid_i;
      ex_inst_addr_o    <= id_inst_addr_i;
      ex_reg1_data_o    <= id_reg1_data_i;
      ex_reg2_data_o    <= id_reg2_data_i;
      ex_csr_data_o     <= id_csr_data_i;
      ex_imm_o          <= id_imm_i;
      ex_alu_op_o       <= id_alu_op_i;
      ex_reg_wr_en_o    <= id_reg_wr_en_i;
      ex_reg_wr_adder_o <= id_reg_wr_adder_i;
      ex_csr_wr_en_o    <= id_csr_wr_en_i;
      ex_csr_wr_adder_o <= id_csr_wr_adder_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional event counters.
  // ---------------------------------------------------------------------------
`ifdef ROOTH_FLOW_CNT_EN
  flow_sat_cnt u_bubble_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (hazard_stall),
    .cnt_o (bubble_cnt_o)
  );

  // Every accepted jump counts, including a reload while already flushing.
  flow_sat_cnt u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (jump_flush_i),
    .cnt_o (flush_cnt_o)
  );
`else
  assign bubble_cnt_o = 32'd0;
  assign flush_cnt_o  = 32'd0;
`endif

endmodule : id_ex_flow_reg

`default_nettype wire

// File: tb/tb_id_ex_flow_reg.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_id_ex_flow_reg                                                |
// | Purpose : Self-checking bench for id_ex_flow_reg (FLUSH_CYCLES=2).         |
// |           Directed steps push expected EX contents to a scoreboard queue   |
// |           and pop/compare them one clock later.                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_flow_reg;
  import id_ex_flow_reg_pkg::*;

  localparam int AW = 5;
  localparam int PW = 1 + 5*CPU_W + AW + 1 + REG_AW + 1 + CSR_AW;
`ifdef ROOTH_FLOW_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic [PW-1:0] payload;
    logic [31:0]   bub;
    logic [31:0]   fl;
  } exp_t;

  exp_t sb[$];

  logic              clk = 1'b0;
  logic              rst_i;
  logic              id_valid_i;
  logic [CPU_W-1:0]  id_inst_addr_i, id_reg1_data_i, id_reg2_data_i, id_csr_data_i, id_imm_i;
  logic [AW-1:0]     id_alu_op_i;
  logic              id_reg_wr_en_i;
  logic [REG_AW-1:0] id_reg_wr_adder_i;
  logic              id_csr_wr_en_i;
  logic [CSR_AW-1:0] id_csr_wr_adder_i;
  logic              flow_wait_fc_i, jump_flush_i;
  logic              ex_valid_o;
  logic [CPU_W-1:0]  ex_inst_addr_o, ex_reg1_data_o, ex_reg2_data_o, ex_csr_data_o, ex_imm_o;
  logic [AW-1:0]     ex_alu_op_o;
  logic              ex_reg_wr_en_o;
  logic [REG_AW-1:0] ex_reg_wr_adder_o;
  logic              ex_csr_wr_en_o;
  logic [CSR_AW-1:0] ex_csr_wr_adder_o;
  logic              hold_pc_o, hold_id_o;
  logic [31:0]       bubble_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_flow_reg #(.ALU_OP_WIDTH(AW), .FLUSH_CYCLES(2)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .id_valid_i        (id_valid_i),
    .id_inst_addr_i    (id_inst_addr_i),
    .id_reg1_data_i    (id_reg1_data_i),
    .id_reg2_data_i    (id_reg2_data_i),
    .id_csr_data_i     (id_csr_data_i),
    .id_imm_i          (id_imm_i),
    .id_alu_op_i       (id_alu_op_i),
    .id_reg_wr_en_i    (id_reg_wr_en_i),
    .id_reg_wr_adder_i (id_reg_wr_adder_i),
    .id_csr_wr_en_i    (id_csr_wr_en_i),
    .id_csr_wr_adder_i (id_csr_wr_adder_i),
    .flow_wait_fc_i    (flow_wait_fc_i),
    .jump_flush_i      (jump_flush_i),
    .ex_valid_o        (ex_valid_o),
    .ex_inst_addr_o    (ex_inst_addr_o),
    .ex_reg1_data_o    (ex_reg1_data_o),
    .ex_reg2_data_o    (ex_reg2_data_o),
    .ex_csr_data_o     (ex_csr_data_o),
    .ex_imm_o          (ex_imm_o),
    .ex_alu_op_o       (ex_alu_op_o),
    .ex_reg_wr_en_o    (ex_reg_wr_en_o),
    .ex_reg_wr_adder_o (ex_reg_wr_adder_o),
    .ex_csr_wr_en_o    (ex_csr_wr_en_o),
    .ex_csr_wr_adder_o (ex_csr_wr_adder_o),
    .hold_pc_o         (hold_pc_o),
    .hold_id_o         (hold_id_o),
    .bubble_cnt_o      (bubble_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  // Stimulus encoding: every ID field is derived from (valid, pc, d).
  function automatic logic [PW-1:0] payload_of(input logic v, input logic [31:0] pc,
                                               input logic [31:0] d);
    logic [31:0] csr_val;
    logic [31:0] imm_val;
    csr_val = d ^ 32'hA5A5_0000;
    imm_val = d + 32'd1;
    return {v, pc, d, ~d, csr_val, imm_val, d[AW-1:0], 1'b1,
            pc[REG_AW-1:0], 1'b1, pc[CSR_AW-1:0]};
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational holds, push expected
  // EX state, then pop and compare #1 after the rising edge.
  task automatic step(input string tag, input logic rst, input logic v, input logic wt,
                      input logic jmp, input logic [31:0] pc, input logic [31:0] d,
                      input logic cap, input logic hold, input logic [31:0] bub,
                      input logic [31:0] fl);
    exp_t e;
    exp_t got;
    logic [PW-1:0] obs;
    @(negedge clk);
    rst_i             = rst;
    id_valid_i        = v;
    id_inst_addr_i    = pc;
    id_reg1_data_i    = d;
    id_reg2_data_i    = ~d;
    id_csr_data_i     = d ^ 32'hA5A5_0000;
    id_imm_i          = d + 32'd1;
    id_alu_op_i       = d[AW-1:0];
    id_reg_wr_en_i    = 1'b1;
    id_reg_wr_adder_i = pc[REG_AW-1:0];
    id_csr_wr_en_i    = 1'b1;
    id_csr_wr_adder_i = pc[CSR_AW-1:0];
    flow_wait_fc_i    = wt;
    jump_flush_i      = jmp;
    #1;
    check({tag, "/hold_pc"}, PW'(hold_pc_o), PW'(hold));
    check({tag, "/hold_id"}, PW'(hold_id_o), PW'(hold));
    e.payload = cap ? payload_of(v, pc, d) : '0;
    e.bub     = CNT_ON ? bub : 32'd0;
    e.fl      = CNT_ON ? fl  : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s/scoreboard: observed empty expected entry", tag);
    end else begin
      got = sb.pop_front();
      obs = {ex_valid_o, ex_inst_addr_o, ex_reg1_data_o, ex_reg2_data_o, ex_csr_data_o,
             ex_imm_o, ex_alu_op_o, ex_reg_wr_en_o, ex_reg_wr_adder_o, ex_csr_wr_en_o,
             ex_csr_wr_adder_o};
      check({tag, "/ex_valid"}, PW'(ex_valid_o), PW'(got.payload[PW-1]));
      check({tag, "/ex_payload"}, obs, got.payload);
      check({tag, "/bubble_cnt"}, PW'(bubble_cnt_o), PW'(got.bub));
      check({tag, "/flush_cnt"}, PW'(flush_cnt_o), PW'(got.fl));
    end
  endtask

  initial begin
    rst_i = 1'b1; id_valid_i = 1'b1; flow_wait_fc_i = 1'b0; jump_flush_i = 1'b0;
    id_inst_addr_i = '0; id_reg1_data_i = '0; id_reg2_data_i = '0; id_csr_data_i = '0;
    id_imm_i = '0; id_alu_op_i = '0; id_reg_wr_en_i = 1'b0; id_reg_wr_adder_i = '0;
    id_csr_wr_en_i = 1'b0; id_csr_wr_adder_i = '0;

    //    tag          rst v  wait jmp pc            d             cap hold bub fl
    step("reset0",     1, 1, 0, 0, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step("reset1",     1, 1, 0, 0, 32'h0000_0044, 32'hCAFE_F00D, 0, 0, 0, 0);
    step("pass",       0, 1, 0, 0, 32'h0000_0105, 32'h0000_1234, 1, 0, 0, 0);
    step("pass_inv",   0, 0, 0, 0, 32'h0000_0108, 32'h5555_AAAA, 1, 0, 0, 0);
    step("lu_hold",    0, 1, 1, 0, 32'h0000_010C, 32'h0BAD_0001, 0, 1, 1, 0);
    step("lu_resume",  0, 1, 1, 0, 32'h0000_010C, 32'h0BAD_0001, 1, 0, 1, 0);
    step("run_after",  0, 1, 0, 0, 32'h0000_0110, 32'h1111_2222, 1, 0, 1, 0);
    step("jump",       0, 1, 0, 0, 32'h0000_0114, 32'h3333_4444, 1, 0, 1, 0);
    step("jump_sq0",   0, 1, 0, 1, 32'h0000_0118, 32'h3333_5555, 0, 0, 1, 1);
    step("jump_sq1",   0, 1, 1, 0, 32'h0000_011C, 32'h3333_6666, 0, 0, 1, 1);
    step("jump_res",   0, 1, 0, 0, 32'h0000_0200, 32'h7777_8888, 1, 0, 1, 1);
    step("coll",       0, 1, 1, 1, 32'h0000_0204, 32'h9999_0000, 0, 0, 1, 2);
    step("coll_rejmp", 0, 1, 0, 1, 32'h0000_0208, 32'h9999_0001, 0, 0, 1, 3);
    step("coll_ext",   0, 1, 0, 0, 32'h0000_020C, 32'h9999_0002, 0, 0, 1, 3);
    step("coll_res",   0, 1, 0, 0, 32'h0000_0210, 32'h9999_0003, 1, 0, 1, 3);
    step("lu2_hold",   0, 1, 1, 0, 32'h0000_0214, 32'hABCD_0000, 0, 1, 2, 3);
    step("bub_jump",   0, 1, 0, 1, 32'h0000_0214, 32'hABCD_0000, 0, 0, 2, 4);
    step("bub_jsq",    0, 1, 0, 0, 32'h0000_0218, 32'hABCD_0001, 0, 0, 2, 4);
    step("bub_jres",   0, 1, 0, 0, 32'h0000_021C, 32'hABCD_0002, 1, 0, 2, 4);
    step("mid_jump",   0, 1, 0, 1, 32'h0000_0300, 32'h0F0F_0F0F, 0, 0, 2, 5);
    step("rst_flush",  1, 1, 0, 1, 32'h0000_0304, 32'hF0F0_F0F0, 0, 0, 0, 0);
    step("post_rstf",  0, 1, 0, 0, 32'h0000_0308, 32'h1357_9BDF, 1, 0, 0, 0);
    step("mid_lu",     0, 1, 1, 0, 32'h0000_030C, 32'h2468_ACE0, 0, 1, 1, 0);
    step("rst_bubble", 1, 1, 1, 0, 32'h0000_030C, 32'h2468_ACE0, 0, 0, 0, 0);
    step("post_rstb",  0, 1, 0, 0, 32'h0000_0310, 32'hFFFF_FFFF, 1, 0, 0, 0);
    step("lu3_hold",   0, 1, 1, 0, 32'h0000_0314, 32'h0000_0000, 0, 1, 1, 0);
    step("lu3_res",    0, 1, 0, 0, 32'h0000_0314, 32'h0000_0000, 1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_id_ex_flow_reg

`default_nettype wire
